// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, one full-adder cell per clock, LSB first.
// A WIDTH-bit add or subtract (a + ~b + 1) completes WIDTH cycles after the accepting edge.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN enables the signed overflow flag (ovf);
// when it is undefined, ovf is tied to 0 and no overflow flop is built.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; operands are loaded on the accepting edge
// ST_SHIFT | one result bit per edge; busy=1; last edge latches outputs
// ST_DONE  | done=1 for one cycle, then back to ST_IDLE

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             sum_bit;
  logic             carry_new;
  logic             last_bit;

  // Single full-adder cell operating on the current LSBs of the shift registers.
  always_comb begin
    sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_new = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    last_bit  = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath update; outputs only change on the edge entering ST_DONE.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    s_sr_d   = s_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          // Subtraction as a + ~b + 1: invert B here and seed the carry with 1.
          b_sr_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          op_d    = sub;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = {sum_bit, s_sr_q[WIDTH-1:1]};
        carry_d = carry_new;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          state_d  = ST_DONE;
          result_d = {sum_bit, s_sr_q[WIDTH-1:1]};
          // For subtraction a borrow is the absence of a carry out.
          c_out_d  = op_q ? ~carry_new : carry_new;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shift registers and held outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      s_sr_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      s_sr_q   <= s_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;

  // On the MSB edge carry_q is the carry into the MSB cell; overflow is it XOR the carry out.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == ST_SHIFT && last_bit) begin
      ovf_d = carry_q ^ carry_new;
    end
  end

  // Overflow flag register, held like result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign c_out  = c_out_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub (WIDTH=8): table-driven add/sub vectors plus
// hand-written sequences for ignored starts and reset during an operation.

module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         ovf;

  int n_cmp;
  int n_err;

  typedef struct {
    string      name;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_res;
    logic       exp_c;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  serial_add_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ovf_exp(input logic v);
`ifdef SERIAL_ADDSUB_OVF_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // Issue one operation and check latency, busy length, outputs and the done pulse.
  task automatic run_op(input string name, input logic s, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] er, input logic ec, input logic eo);
    int          busy_cycles;
    bit          got;
    logic [7:0]  prev_res;
    prev_res = result;
    @(negedge clk);
    start = 1'b1; sub = s; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    check({name, " result held during SHIFT"}, result, prev_res);
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy && done) check({name, " busy&done"}, 1, 0);
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cycles++;
        @(negedge clk);
      end
    end
    check({name, " done seen"}, got, 1);
    check({name, " busy cycles"}, busy_cycles, 8);
    check({name, " result"}, result, er);
    check({name, " c_out"}, c_out, ec);
    check({name, " ovf"}, ovf, ovf_exp(eo));
    @(negedge clk);
    check({name, " done one cycle"}, {busy, done}, 2'b00);
    check({name, " result stable"}, result, er);
  endtask

  initial begin
    int   done_cnt;
    logic [7:0] keep;
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{"add 35+4A", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{"add FF+01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{"sub 10-20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[3] = '{"sub 20-10", 1'b1, 8'h20, 8'h10, 8'h10, 1'b0, 1'b0};
    vecs[4] = '{"add 7F+01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{"sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{"sub 5A-5A", 1'b1, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{"add 80+80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{"add 00+00", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{"sub 00-01", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset c_out", c_out, 0);
    check("reset ovf", ovf, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b,
             vecs[i].exp_res, vecs[i].exp_c, vecs[i].exp_ovf);
    end

    // Starts during SHIFT and DONE must be ignored.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    repeat (2) @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 8'hFF; b = 8'h0F;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    for (int i = 0; i < 20 && done_cnt == 0; i++) begin
      if (done) done_cnt++;
      else @(negedge clk);
    end
    check("ignore first done", done_cnt, 1);
    start = 1'b1; sub = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    check("ignore start in DONE busy", busy, 0);
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("ignore single done", done_cnt, 1);
    check("ignore result", result, 8'h46);
    check("ignore c_out", c_out, 0);

    // Reset in the 4th SHIFT cycle aborts without a done pulse.
    run_op("pre-reset add", 1'b0, 8'h10, 8'h21, 8'h31, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h35; b = 8'h4A;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    keep = result;
    check("abort result", keep, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort c_out", c_out, 0);
    check("abort ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("abort no done", done_cnt, 0);
    run_op("post-reset add", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0);
    run_op("post-reset sub", 1'b1, 8'h20, 8'h10, 8'h10, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
